// File: rtl/jump_control.sv
// Jump condition evaluator: combinational taken decision for the PC mux plus a
// registered, valid-qualified copy and a saturating taken-jump counter.
module jump_control (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_opcode,
  input  logic [2:0] i_status,
  input  logic       i_valid,
  output logic       o_jump,
  output logic       o_jump_r,
  output logic [7:0] o_taken_cnt
);

  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic       taken;
  logic       jump_r_q, jump_r_d;
  logic [7:0] cnt_q, cnt_d;

  // Decode depends only on opcode/status so clock, reset and valid cannot disturb it.
  always_comb begin
    o_jump = 1'b1;
    case (i_opcode)
      2'b01:   o_jump = i_status[0];
      2'b10:   o_jump = i_status[1];
      2'b11:   o_jump = i_status[2];
      default: o_jump = 1'b1;
    endcase
  end

  assign taken    = i_valid & o_jump;
  assign jump_r_d = taken;

  always_comb begin
    cnt_d = cnt_q;
    if (taken && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      jump_r_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      jump_r_q <= jump_r_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_jump_r    = jump_r_q;
  assign o_taken_cnt = cnt_q;

endmodule

// File: tb/tb_jump_control.sv
// Directed bench for jump_control: decode table, registered path via a
// scoreboard queue, counter saturation and asynchronous reset.
module tb_jump_control;

  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] i_opcode;
  logic [2:0] i_status;
  logic       i_valid;
  logic       o_jump;
  logic       o_jump_r;
  logic [7:0] o_taken_cnt;

  typedef struct packed {
    logic       jr;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_cnt = 0;

  jump_control dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_opcode    (i_opcode),
    .i_status    (i_status),
    .i_valid     (i_valid),
    .o_jump      (o_jump),
    .o_jump_r    (o_jump_r),
    .o_taken_cnt (o_taken_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written as an explicit status-bit select.
  function automatic logic ref_jump(input logic [1:0] op, input logic [2:0] st);
    if (op == 2'b00) return 1'b1;
    return st[op - 2'd1];
  endfunction

  // Drive one cycle of inputs, queue the expected registered result, then check it.
  task automatic step(input logic [1:0] op, input logic [2:0] st, input logic vld, input string tag);
    exp_t e;
    exp_t got;
    @(negedge i_clk);
    i_opcode = op;
    i_status = st;
    i_valid  = vld;
    e.jr = vld & ref_jump(op, st);
    if (e.jr && m_cnt < 255) m_cnt++;
    e.cnt = 8'(m_cnt);
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 8'd0, 8'd1);
    end else begin
      got = exp_q.pop_front();
      chk({tag, "_jr"}, {7'd0, o_jump_r}, {7'd0, got.jr});
      chk({tag, "_cnt"}, o_taken_cnt, got.cnt);
    end
  endtask

  logic [4:0] tv_in  [8];
  logic       tv_exp [8];

  initial begin
    tv_in[0] = 5'b00_000; tv_exp[0] = 1'b1;
    tv_in[1] = 5'b00_111; tv_exp[1] = 1'b1;
    tv_in[2] = 5'b01_001; tv_exp[2] = 1'b1;
    tv_in[3] = 5'b01_110; tv_exp[3] = 1'b0;
    tv_in[4] = 5'b10_010; tv_exp[4] = 1'b1;
    tv_in[5] = 5'b10_101; tv_exp[5] = 1'b0;
    tv_in[6] = 5'b11_100; tv_exp[6] = 1'b1;
    tv_in[7] = 5'b11_011; tv_exp[7] = 1'b0;

    i_rst_n  = 1'b0;
    i_opcode = 2'b00;
    i_status = 3'b000;
    i_valid  = 1'b0;
    #1;
    chk("rst_jr", {7'd0, o_jump_r}, 8'd0);
    chk("rst_cnt", o_taken_cnt, 8'd0);

    // Decode table, applied in reset with valid undriven to show neither matters.
    i_valid = 1'bx;
    for (int i = 0; i < 8; i++) begin
      {i_opcode, i_status} = tv_in[i];
      #1;
      chk($sformatf("dec_%05b", tv_in[i]), {7'd0, o_jump}, {7'd0, tv_exp[i]});
    end
    i_valid = 1'b0;

    @(negedge i_clk);
    i_rst_n = 1'b1;

    step(2'b00, 3'b000, 1'b1, "uncond0");
    step(2'b00, 3'b101, 1'b1, "uncond1");
    step(2'b00, 3'b111, 1'b1, "uncond2");
    step(2'b01, 3'b110, 1'b1, "b0_not");
    chk("cnt_after4", o_taken_cnt, 8'd3);
    step(2'b00, 3'b000, 1'b0, "novld0");
    step(2'b00, 3'b000, 1'b0, "novld1");
    chk("cnt_hold", o_taken_cnt, 8'd3);
    step(2'b10, 3'b010, 1'b1, "b1_take");
    step(2'b11, 3'b011, 1'b1, "b2_not");
    step(2'b11, 3'b100, 1'b1, "b2_take");

    for (int i = 0; i < 260; i++) step(2'b00, 3'($urandom_range(0, 7)), 1'b1, "sat");
    chk("sat_cnt", o_taken_cnt, 8'd255);
    chk("sat_pulse", {7'd0, o_jump_r}, 8'd1);

    // Reset between edges: registered state clears at once, decode keeps working.
    @(negedge i_clk);
    #2;
    i_opcode = 2'b11;
    i_status = 3'b100;
    i_valid  = 1'b1;
    i_rst_n  = 1'b0;
    #1;
    chk("arst_jr", {7'd0, o_jump_r}, 8'd0);
    chk("arst_cnt", o_taken_cnt, 8'd0);
    chk("arst_dec1", {7'd0, o_jump}, 8'd1);
    i_status = 3'b011;
    #1;
    chk("arst_dec0", {7'd0, o_jump}, 8'd0);
    @(posedge i_clk);
    #1;
    chk("arst_hold_cnt", o_taken_cnt, 8'd0);
    m_cnt = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(2'b00, 3'b000, 1'b1, "post_rst");
    step(2'b01, 3'b001, 1'b1, "post_rst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
